bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
Parametrised successor of the microwave mm:ss timer. It holds a BCD time value entered digit-by-digit from the keypad (shift-in from the right). The value counts down one second per tick strobe and supports start, pause, resume and clear. It sits between the keypad decoder and the display/magnetron controller. It flags zero, reports running/paused status, and emits a one-cycle done pulse when a countdown expires.

Parameters:
MIN_DIGITS, 2, number of BCD minute digits (legal 1..3); minutes field width = 4*MIN_DIGITS.

Ports:
clock  in  1  system clock, all state updates on rising edge.
clrn  in  1  asynchronous active-low reset.
tick  in  1  one-cycle 1 Hz strobe; decrements while running.
key_valid  in  1  one-cycle strobe, key_data valid.
key_data  in  4  BCD key code; values 10..15 ignored.
clear_entry  in  1  clear value / abort.
start  in  1  start or resume.
pause  in  1  pause a running count.
sec_ones  out  4  seconds units digit.
sec_tens  out  4  seconds tens digit.
mins  out  4*MIN_DIGITS  minute digits, least-significant digit in [3:0].
running  out  1  high in RUN.
paused  out  1  high in PAUSED.
zero  out  1  all digits zero.
done  out  1  one-cycle pulse on expiry.

Behaviour:
- Reset (clrn low, async): state IDLE, all digits 0, zero=1, running=0, paused=0, done=0. Reset mid-count aborts with no done pulse.
- All outputs are registered. running, paused and zero reflect the state and value after the same edge.
- States: IDLE, RUN, PAUSED.
- Same-cycle priority: clear_entry > pause > start > tick > key_valid.
- IDLE, key_valid with key_data<=9: shift left. key_data goes to sec_ones, sec_ones to sec_tens, sec_tens to mins LSD, and each min digit to the next. The MSD is discarded.
- IDLE, key_data>9: no change.
- IDLE, clear_entry: all digits cleared to 0.
- IDLE, start with zero=0: go to RUN. The value is unchanged that cycle.
- IDLE, start with zero=1: ignored.
- IDLE, tick: ignored.
- RUN, tick: decrement the value by one second.
  - sec_ones>0: sec_ones-1.
  - Else sec_ones=9 and borrow into sec_tens. If sec_tens>0 then sec_tens-1, else sec_tens=5 and borrow into the minutes.
  - Minutes decrement as a plain BCD chain (digit 0 reloads 9 and borrows upward).
- Non-normalised entries are legal: sec_tens 6..9 (e.g. 0:90 counts 90 s) and minutes up to all 9s. Once sec_tens reaches 0 it reloads 5.
- RUN, tick that makes the value 0:00: state goes to IDLE and done=1 for exactly the following cycle.
- RUN, pause: go to PAUSED. A tick in the same cycle is dropped.
- RUN, clear_entry: go to IDLE, value cleared, no done pulse.
- RUN, keys and start: ignored.
- PAUSED, start: go to RUN. A tick in the same cycle is dropped.
- PAUSED, clear_entry: go to IDLE, value cleared.
- PAUSED, tick/keys/pause: ignored; value held.
- Borrow never propagates past the MSD. A nonzero value cannot underflow because expiry occurs at 0:00.

Decomposition:
- timer_pkg holds:
  - the state encoding (IDLE/RUN/PAUSED);
  - the BCD constants DIGIT_MAX=4'd9 and SEC_TENS_RELOAD=4'd5;
  - the function is_bcd(key).
- Sub-module bcd_digit_dec, instantiated 2+MIN_DIGITS times:
  - inputs: digit, borrow_in, reload value;
  - outputs: next digit, borrow_out (digit==0 & borrow_in);
  - purely combinational.
- The top level owns the FSM, the shift register and the registered outputs.

Test Plan:
1. Reset with clrn low mid-RUN at 1:23 → all digits 0, zero=1, running=0, done never pulses.
2. IDLE, keys 1,3,0, start, then 5 ticks → value reads 1:30 before start, then 1:25; running=1 throughout.
3. Value 1:00, one tick → 0:59 (sec_tens reload 5, min borrow).
4. Value 0:90, 90 ticks → reaches 0:00 on the 90th tick; done=1 for exactly one cycle; state IDLE.
5. RUN at 0:10, pause asserted with a tick in the same cycle → value stays 0:10, paused=1; ten ticks leave it unchanged. Then start → running=1, and the next tick gives 0:09.
6. MIN_DIGITS=2 with keys 9,9,9,9,9 → value 99:99 (MSD discarded); key 12 is ignored; start with value 0:00 is ignored; clear_entry in PAUSED → 0:00, IDLE, no done.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared state encoding and BCD constants for the keypad countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_e;

   localparam logic [3:0] DIGIT_MAX       = 4'd9;
   localparam logic [3:0] SEC_TENS_RELOAD = 4'd5;

   function automatic logic is_bcd(input logic [3:0] key);
      return key <= DIGIT_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One stage of the BCD borrow chain: decrements a digit when borrowed from,
// reloading the given value and passing the borrow upward when it was zero.
module bcd_digit_dec (
   input  logic [3:0] digit,
   input  logic       borrow_in,
   input  logic [3:0] reload,
   output logic [3:0] digit_nxt,
   output logic       borrow_out
);

   always_comb begin
      borrow_out = borrow_in && (digit == 4'd0);
      if (!borrow_in)
         digit_nxt = digit;
      else if (digit == 4'd0)
         digit_nxt = reload;
      else
         digit_nxt = digit - 4'd1;
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer: keypad shift-in entry, start/pause/resume/clear,
// one-second decrement on tick and a single-cycle done pulse on expiry.
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int MIN_DIGITS = 2
) (
   input  logic                    clock,
   input  logic                    clrn,
   input  logic                    tick,
   input  logic                    key_valid,
   input  logic [3:0]              key_data,
   input  logic                    clear_entry,
   input  logic                    start,
   input  logic                    pause,
   output logic [3:0]              sec_ones,
   output logic [3:0]              sec_tens,
   output logic [4*MIN_DIGITS-1:0] mins,
   output logic                    running,
   output logic                    paused,
   output logic                    zero,
   output logic                    done
);

   // Digit 0 is seconds units, digit 1 seconds tens, digits 2.. are minutes.
   localparam int NDIG = 2 + MIN_DIGITS;

   logic [NDIG-1:0][3:0] dig_q, dig_d, dig_dec, dig_shift;
   logic [NDIG:0]        borrow;
   logic                 borrow_unused;
   state_e               state_q, state_d;
   logic                 done_q, done_d;
   logic                 zero_q, zero_d;
   logic                 running_q, running_d;
   logic                 paused_q, paused_d;

   assign borrow[0]     = 1'b1;
   assign borrow_unused = borrow[NDIG];

   for (genvar gi = 0; gi < NDIG; gi++) begin : g_dec
      bcd_digit_dec u_dec (
         .digit      (dig_q[gi]),
         .borrow_in  (borrow[gi]),
         .reload     ((gi == 1) ? SEC_TENS_RELOAD : DIGIT_MAX),
         .digit_nxt  (dig_dec[gi]),
         .borrow_out (borrow[gi+1])
      );
   end

   assign dig_shift = {dig_q[NDIG-2:0], key_data};

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      done_d  = 1'b0;
      if (clear_entry) begin
         state_d = ST_IDLE;
         dig_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !zero_q)
                  state_d = ST_RUN;
               else if (key_valid && is_bcd(key_data))
                  dig_d = dig_shift;
            end
            ST_RUN: begin
               if (pause)
                  state_d = ST_PAUSED;
               else if (tick) begin
                  dig_d = dig_dec;
                  // Expiry is detected on the post-decrement value, so the
                  // borrow chain can never wrap past the top digit.
                  if (dig_dec == '0) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_PAUSED: begin
               if (start)
                  state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      zero_d    = (dig_d == '0);
      running_d = (state_d == ST_RUN);
      paused_d  = (state_d == ST_PAUSED);
   end

   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         state_q   <= ST_IDLE;
         dig_q     <= '0;
         done_q    <= 1'b0;
         zero_q    <= 1'b1;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         dig_q     <= dig_d;
         done_q    <= done_d;
         zero_q    <= zero_d;
         running_q <= running_d;
         paused_q  <= paused_d;
      end
   end

   assign sec_ones = dig_q[0];
   assign sec_tens = dig_q[1];
   assign mins     = dig_q[NDIG-1:2];
   assign running  = running_q;
   assign paused   = paused_q;
   assign zero     = zero_q;
   assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: the model keeps the time as whole
// minutes and seconds integers; a monitor checks every registered output set.
module tb_bcd_countdown_timer;

   localparam int MIN_DIGITS = 2;
   localparam int NDIG       = 2 + MIN_DIGITS;

   logic                    clock = 1'b0;
   logic                    clrn = 1'b1;
   logic                    tick = 1'b0;
   logic                    key_valid = 1'b0;
   logic [3:0]              key_data = 4'd0;
   logic                    clear_entry = 1'b0;
   logic                    start = 1'b0;
   logic                    pause = 1'b0;
   logic [3:0]              sec_ones, sec_tens;
   logic [4*MIN_DIGITS-1:0] mins;
   logic                    running, paused, zero, done;

   typedef struct packed {
      logic [3:0]              so;
      logic [3:0]              st;
      logic [4*MIN_DIGITS-1:0] mn;
      logic                    run;
      logic                    pau;
      logic                    zr;
      logic                    dn;
   } obs_t;

   obs_t exp_q[$];
   obs_t mon_e, mon_a;
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: 0 idle, 1 run, 2 paused; time as integers.
   int   m_state = 0;
   int   m_min = 0;
   int   m_sec = 0;
   logic m_done = 1'b0;
   int   mod_all = 1;

   bcd_countdown_timer #(.MIN_DIGITS(MIN_DIGITS)) dut (
      .clock       (clock),
      .clrn        (clrn),
      .tick        (tick),
      .key_valid   (key_valid),
      .key_data    (key_data),
      .clear_entry (clear_entry),
      .start       (start),
      .pause       (pause),
      .sec_ones    (sec_ones),
      .sec_tens    (sec_tens),
      .mins        (mins),
      .running     (running),
      .paused      (paused),
      .zero        (zero),
      .done        (done)
   );

   always #5 clock = ~clock;

   function automatic obs_t model_obs();
      obs_t o;
      int   mm;
      o.so = 4'(m_sec % 10);
      o.st = 4'(m_sec / 10);
      mm   = m_min;
      for (int i = 0; i < MIN_DIGITS; i++) begin
         o.mn[4*i +: 4] = 4'(mm % 10);
         mm = mm / 10;
      end
      o.run = (m_state == 1);
      o.pau = (m_state == 2);
      o.zr  = (m_min == 0 && m_sec == 0);
      o.dn  = m_done;
      return o;
   endfunction

   task automatic model_step(input logic kv, input logic [3:0] kd, input logic clr,
                             input logic st, input logic pa, input logic tk);
      int d;
      m_done = 1'b0;
      if (clr) begin
         m_state = 0; m_min = 0; m_sec = 0;
      end else if (m_state == 0) begin
         if (st && (m_min != 0 || m_sec != 0))
            m_state = 1;
         else if (kv && kd <= 4'd9) begin
            d = ((m_min * 100 + m_sec) * 10 + int'(kd)) % mod_all;
            m_min = d / 100;
            m_sec = d % 100;
         end
      end else if (m_state == 1) begin
         if (pa)
            m_state = 2;
         else if (tk) begin
            if (m_sec > 0) m_sec = m_sec - 1;
            else begin m_sec = 59; m_min = m_min - 1; end
            if (m_min == 0 && m_sec == 0) begin m_state = 0; m_done = 1'b1; end
         end
      end else if (st)
         m_state = 1;
   endtask

   task automatic cyc(input logic kv, input logic [3:0] kd, input logic clr,
                      input logic st, input logic pa, input logic tk);
      @(negedge clock);
      key_valid = kv; key_data = kd; clear_entry = clr;
      start = st; pause = pa; tick = tk;
      model_step(kv, kd, clr, st, pa, tk);
      exp_q.push_back(model_obs());
      @(posedge clock);
   endtask

   task automatic do_key(input int k);  cyc(1'b1, 4'(k), 1'b0, 1'b0, 1'b0, 1'b0); endtask
   task automatic do_tick();            cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
   task automatic do_start();           cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
   task automatic do_clear();           cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
   task automatic do_idle();            cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_sec_ones", 32'(sec_ones), 32'd0);
      chk("rst_sec_tens", 32'(sec_tens), 32'd0);
      chk("rst_mins", 32'(mins), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_paused", 32'(paused), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
   endtask

   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {sec_ones, sec_tens, mins, running, paused, zero, done};
         vectors++;
         if (mon_a !== mon_e) begin
            miscompares++;
            $display("FAIL obs: got so=%0d st=%0d mins=%h run=%b pau=%b zero=%b done=%b, want so=%0d st=%0d mins=%h run=%b pau=%b zero=%b done=%b",
                     mon_a.so, mon_a.st, mon_a.mn, mon_a.run, mon_a.pau, mon_a.zr, mon_a.dn,
                     mon_e.so, mon_e.st, mon_e.mn, mon_e.run, mon_e.pau, mon_e.zr, mon_e.dn);
         end
      end
   end

   initial begin
      int r;
      int kd;
      for (int i = 0; i < NDIG; i++) mod_all = mod_all * 10;

      // Power-on reset.
      #1 clrn = 1'b0;
      #2 chk_reset_outputs();
      @(negedge clock);
      clrn = 1'b1;

      // Entry 1:30, start, five ticks down to 1:25.
      do_key(1); do_key(3); do_key(0);
      do_start();
      repeat (5) begin do_tick(); do_idle(); end

      // 1:00 -> 0:59.
      do_clear(); do_key(1); do_key(0); do_key(0); do_start(); do_tick();

      // Non-normalised 0:90 runs 90 seconds then expires with one done pulse.
      do_clear(); do_key(9); do_key(0); do_start();
      repeat (90) do_tick();
      do_idle(); do_idle();

      // Pause with a simultaneous tick, ticks while paused, resume.
      do_clear(); do_key(1); do_key(0); do_start();
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (10) do_tick();
      cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      do_tick();

      // MSD discard, invalid key, start at zero, clear in PAUSED.
      do_clear();
      repeat (5) do_key(9);
      do_key(12);
      do_clear(); do_start(); do_tick();
      do_key(5); do_start(); cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      do_clear(); do_idle();

      // Randomised traffic.
      for (int n = 0; n < 800; n++) begin
         r  = $urandom_range(0, 99);
         kd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
         if (r < 30)      do_key(kd);
         else if (r < 55) do_tick();
         else if (r < 62) do_start();
         else if (r < 67) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         else if (r < 70) do_clear();
         else if (r < 75) begin
            if (m_state == 1) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            else do_tick();
         end else if (r < 80) begin
            if (m_state != 1) cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            else do_tick();
         end else if (r < 83)
            cyc(1'($urandom_range(0, 1)), 4'(kd), 1'b1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else do_idle();
      end

      // Asynchronous reset mid-count at 1:23 aborts without done.
      do_clear(); do_key(1); do_key(2); do_key(4); do_start(); do_tick();
      #3 clrn = 1'b0;
      m_state = 0; m_min = 0; m_sec = 0; m_done = 1'b0;
      #1 chk_reset_outputs();
      repeat (3) begin
         @(posedge clock);
         #1;
         chk("rst_hold_done", 32'(done), 32'd0);
         chk("rst_hold_running", 32'(running), 32'd0);
      end
      @(negedge clock);
      clrn = 1'b1;
      do_tick(); do_tick(); do_idle();

      #3;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
